// File: rtl/sha256_msg_loader.sv
// Host-side loader for the SHA-256 hasher: writes the padded message to shared memory, starts the hasher, streams back 8 hash words.
// Optional LOADER_BYTE_SWAP_EN: byte-reverse each incoming message word before it is written (little-endian hosts).
module sha256_msg_loader #(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] msg_base_addr_i,
  input  logic [15:0] hash_base_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        mem_own_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        hash_start_o,
  input  logic        hash_done_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  localparam int PAD_WORDS = 16 * ((NUM_OF_WORDS + 3 + 15) / 16);
  localparam int CW = $clog2(PAD_WORDS + 1);
  localparam logic [CW-1:0] LAST_MSG = CW'(NUM_OF_WORDS - 1);
  localparam logic [CW-1:0] FIRST_PAD = CW'(NUM_OF_WORDS);
  localparam logic [CW-1:0] LAST_PAD = CW'(PAD_WORDS - 1);
  localparam logic [31:0] LEN_LO = 32'(NUM_OF_WORDS * 32);

  typedef enum logic [3:0] {
    IDLE, LOAD, PAD, START, WAIT_LO, WAIT_HI, RD_ADDR, RD_DATA, OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [15:0]   msg_base_q, msg_base_d, hash_base_q, hash_base_d;
  logic          mem_own_q, mem_own_d, mem_we_q, mem_we_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          hash_start_q, hash_start_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;

  function automatic logic [31:0] in_word(input logic [31:0] w);
`ifdef LOADER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Upper length word (offset PAD_WORDS-2) is always zero for the supported message sizes.
  function automatic logic [31:0] pad_word(input logic [CW-1:0] off);
    if (off == FIRST_PAD) return 32'h8000_0000;
    if (off == LAST_PAD) return LEN_LO;
    return 32'h0;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    msg_base_d   = msg_base_q;
    hash_base_d  = hash_base_q;
    mem_own_d    = mem_own_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hash_start_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          msg_base_d  = msg_base_addr_i;
          hash_base_d = hash_base_addr_i;
          cnt_d       = CW'(1);
          mem_we_d    = 1'b1;
          mem_addr_d  = msg_base_addr_i;
          mem_wdata_d = in_word(in_data_i);
          state_d     = (NUM_OF_WORDS == 1) ? PAD : LOAD;
        end
      end
      LOAD: begin
        if (in_valid_i) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = msg_base_q + 16'(cnt_q);
          mem_wdata_d = in_word(in_data_i);
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == LAST_MSG) state_d = PAD;
        end
      end
      PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = msg_base_q + 16'(cnt_q);
        mem_wdata_d = pad_word(cnt_q);
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST_PAD) state_d = START;
      end
      START: begin
        mem_own_d    = 1'b0;
        hash_start_d = 1'b1;
        state_d      = WAIT_LO;
      end
      WAIT_LO: if (!hash_done_i) state_d = WAIT_HI;
      WAIT_HI: begin
        if (hash_done_i) begin
          mem_own_d  = 1'b1;
          rcnt_d     = 3'd0;
          mem_addr_d = hash_base_q;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        out_data_d  = mem_rdata_i;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (rcnt_q == 3'd7) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            rcnt_d     = rcnt_q + 3'd1;
            mem_addr_d = hash_base_q + 16'(rcnt_q) + 16'd1;
            state_d    = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      msg_base_q   <= '0;
      hash_base_q  <= '0;
      mem_own_q    <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hash_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      msg_base_q   <= msg_base_d;
      hash_base_q  <= hash_base_d;
      mem_own_q    <= mem_own_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hash_start_q <= hash_start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // in_ready is forced low while reset is held so it reads 0 alongside the registered outputs.
  assign in_ready_o   = ((state_q == IDLE) || (state_q == LOAD)) && !rst_i;
  assign busy_o       = (state_q != IDLE);
  assign mem_own_o    = mem_own_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hash_start_o = hash_start_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;

endmodule

// File: doc/sha256_msg_loader.md
Name: sha256_msg_loader

Overview:
- Host-side front end for the simplified SHA-256 hasher.
- Accepts a raw message as a stream of 32-bit words, writes the padded message into the shared word-addressed memory at msg_base_addr, pulses hash_start, waits for the hasher to finish, reads the 8 hash words back from hash_base_addr and streams them out.
- Writer for the hasher's reader; reader for the hasher's writer.

Parameters:
NUM_OF_WORDS, 40, raw message length in 32-bit words (1..1000)
PAD_WORDS, 16*ceil((NUM_OF_WORDS+3)/16), derived localparam, padded length in words (48 for default)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous active-high reset
msg_base_addr  in  16  word address where the padded message is written; sampled on first accepted input word
hash_base_addr  in  16  word address of the 8-word hash result; sampled with msg_base_addr
in_valid  in  1  raw message word valid
in_data  in  32  raw message word
in_ready  out  1  loader accepts in_data this cycle
mem_own  out  1  1 = loader drives memory bus; 0 = hasher owns it (external mux select)
mem_we  out  1  memory write enable
mem_addr  out  16  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; synchronous, valid 1 cycle after address
hash_start  out  1  one-cycle start pulse to hasher
hash_done  in  1  hasher done level (high while hasher is idle)
out_valid  out  1  hash word valid
out_data  out  32  hash word, hash0 first
out_ready  in  1  consumer accepts out_data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0, mem_own=1, mem_we=0, mem_addr=0, mem_wdata=0, hash_start=0, out_valid=0, out_data=0, busy=0. State goes to IDLE, all counters go to 0.
- All mem_*, hash_start and out_* outputs are registered. in_ready is decoded from state.
- States are IDLE, LOAD, PAD, START, WAIT_LO, WAIT_HI, RD_ADDR, RD_DATA, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch both base addresses and set cnt=1.
  - Next cycle: mem_we=1, mem_addr=msg_base_addr, mem_wdata=word. Go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word k is written at base+k on the following cycle. Gaps in in_valid leave mem_we=0.
  - After word NUM_OF_WORDS-1 is accepted, go to PAD. in_ready=0 from that point.
- PAD: one write per cycle at offsets NUM_OF_WORDS..PAD_WORDS-1.
  - Offset NUM_OF_WORDS: 32'h80000000.
  - Offset PAD_WORDS-2: upper 32 bits of the 64-bit bit length (0 for allowed sizes).
  - Offset PAD_WORDS-1: NUM_OF_WORDS*32, mod 2^32.
  - All other offsets: 0.
  - Go to START.
- START: mem_we=0, mem_own=0, hash_start=1 for exactly one cycle. Go to WAIT_LO.
- WAIT_LO: wait for hash_done=0, i.e. hasher left idle. Then go to WAIT_HI.
- WAIT_HI: wait for hash_done=1. Then set mem_own=1, rcnt=0, and go to RD_ADDR.
- RD_ADDR: mem_addr=hash_base_addr+rcnt, mem_we=0. Go to RD_DATA.
- RD_DATA: capture mem_rdata into out_data, set out_valid=1. Go to OUT.
- OUT: hold out_valid and out_data stable until out_ready.
  - On acceptance, out_valid=0 next cycle.
  - If rcnt==7, go to IDLE; otherwise increment rcnt and go to RD_ADDR.
- Throughput: at most 1 word per 3 cycles on the output.
- Boundaries:
  - out_valid and out_ready high together in the OUT entry cycle counts as acceptance.
  - in_valid asserted outside IDLE/LOAD is ignored; in_ready=0 there.
  - 16-bit address addition wraps mod 2^16.
  - rst asserted in any state returns all outputs to reset values on the same edge. A partially written message is abandoned.
  - When NUM_OF_WORDS+3 is a multiple of 16 there are no zero-fill words between 0x80000000 and the length words.

Optional Feature:
LOADER_BYTE_SWAP_EN
- Defined: each accepted in_data word is byte-reversed before the memory write ({b0,b1,b2,b3}), for little-endian hosts. Padding, length words and hash output are not swapped.
- Undefined: in_data is written unmodified.

Test Plan:
- NUM_OF_WORDS=40, words 0..39 = 32'h00000000+k, no gaps, msg_base=16'h0000 -> mem writes at 0..47: words 0..39 as sent, [40]=32'h80000000, [41..46]=0, [47]=32'h00000500. hash_start pulses once, exactly one cycle after the write to address 47.
- Hasher model drops hash_done 2 cycles after start and raises it 70 cycles later; hash_base=16'h0100 preloaded with 32'hA0..A7 -> reads at 0x100..0x107, out_data sequence 32'hA0..A7, then busy=0.
- out_ready held 0 for 5 cycles on each word -> out_data stable while out_valid=1; exactly 8 transfers; no duplicated or skipped word.
- in_valid toggling 1,0,1,0 -> mem_we only in cycles after accepts; addresses stay contiguous; total writes=48.
- rst pulsed mid-LOAD after 10 words -> outputs at reset values immediately (async); a new 40-word stream starts again at msg_base offset 0.
- NUM_OF_WORDS=13 build -> PAD_WORDS=16: [13]=32'h80000000, [14]=0, [15]=32'h000001A0. With LOADER_BYTE_SWAP_EN, input 32'h11223344 is written as 32'h44332211.
